// File: rtl/if_stage_prefetch_if.sv
// Consumer/redirect/imem-write bundle for the instruction fetch prefetch stage.
// The master drives the requests; the prefetch stage is the slave.
interface if_stage_prefetch_if;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        valid;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [31:0] fetch_count;

    modport master (
        output freeze, Branch_taken, BranchAddr, imem_we, imem_waddr, imem_wdata,
        input  valid, PC, Instruction, fetch_count
    );

    modport slave (
        input  freeze, Branch_taken, BranchAddr, imem_we, imem_waddr, imem_wdata,
        output valid, PC, Instruction, fetch_count
    );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction fetch stage: local instruction memory feeding a small prefetch FIFO.
// A taken branch flushes the FIFO and redirects the fetch pointer.
module if_stage_prefetch #(
    parameter int          IMEM_WORDS = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic               clk,
    input logic               rst_n,
    if_stage_prefetch_if.slave bus
);
    localparam int AW = $clog2(IMEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [31:0] mem      [IMEM_WORDS];
    logic [31:0] bufPc    [FIFO_DEPTH];
    logic [31:0] bufInstr [FIFO_DEPTH];

    logic [31:0] fpc;
    logic [31:0] fetchCount;
    logic [PW:0] rdPtr;
    logic [PW:0] wrPtr;
    logic [31:0] fetchWord;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        unusedBits;

    assign unusedBits = ^{bus.imem_waddr[31:AW+2], bus.imem_waddr[1:0], bus.BranchAddr[1:0]};

    // Read-before-write: a same-cycle fetch of the written word sees the old data.
    assign fetchWord = mem[fpc[AW+1:2]];

    assign empty = (rdPtr == wrPtr);
    assign full  = (rdPtr[PW] != wrPtr[PW]) && (rdPtr[PW-1:0] == wrPtr[PW-1:0]);
    assign pop   = !empty && !bus.freeze && !bus.Branch_taken;
    assign push  = (!full || pop) && !bus.Branch_taken;

    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr[AW+1:2]] <= bus.imem_wdata;
        end
    end

    // Entry storage needs no reset; outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            bufPc[wrPtr[PW-1:0]]    <= fpc + 32'd4;
            bufInstr[wrPtr[PW-1:0]] <= fetchWord;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc        <= RESET_PC;
            rdPtr      <= '0;
            wrPtr      <= '0;
            fetchCount <= '0;
        end else if (bus.Branch_taken) begin
            fpc   <= {bus.BranchAddr[31:2], 2'b00};
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
                fpc   <= fpc + 32'd4;
            end
            if (pop) begin
                rdPtr      <= rdPtr + PTR_ONE;
                fetchCount <= fetchCount + 32'd1;
            end
        end
    end

    always_comb begin
        bus.valid       = !empty;
        bus.PC          = 32'h0;
        bus.Instruction = 32'h0;
        bus.fetch_count = fetchCount;
        if (!empty) begin
            bus.PC          = bufPc[rdPtr[PW-1:0]];
            bus.Instruction = bufInstr[rdPtr[PW-1:0]];
        end
    end
endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch: expected head entries are queued as the
// fetch stream is set up and compared as the consumer pops them.
module tb_if_stage_prefetch;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic rst_n;
    if_stage_prefetch_if bus ();

    if_stage_prefetch #(
        .IMEM_WORDS(64),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] expCount = 0;
    logic [31:0] tbMem [64];
    entry_t      sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] addr);
        entry_t e;
        e.pc    = addr + 32'd4;
        e.instr = tbMem[addr[7:2]];
        sb.push_back(e);
    endtask

    task automatic drain(input int n);
        entry_t e;
        bus.freeze = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) begin
                chk("sbUnderflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("popValid", {31'b0, bus.valid}, 32'd1);
                chk("popPC", bus.PC, e.pc);
                chk("popInstr", bus.Instruction, e.instr);
                step();
                expCount++;
                chk("popCount", bus.fetch_count, expCount);
            end
        end
    endtask

    task automatic branchTo(input logic [31:0] addr);
        bus.Branch_taken = 1'b1;
        bus.BranchAddr   = addr;
        step();
        bus.Branch_taken = 1'b0;
        bus.BranchAddr   = 32'h0;
        chk("brValid0", {31'b0, bus.valid}, 32'd0);
        chk("brCount", bus.fetch_count, expCount);
        step();
        sb.delete();
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "Valid"}, {31'b0, bus.valid}, 32'd0);
        chk({tag, "PC"}, bus.PC, 32'd0);
        chk({tag, "Instr"}, bus.Instruction, 32'd0);
        chk({tag, "Count"}, bus.fetch_count, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tbMem[i] = {8'hC0, 8'(i), 16'(i * 7 + 3)};
        end
        tbMem[0] = 32'hE3A00014;
        tbMem[1] = 32'hE3A01A01;

        rst_n            = 1'b0;
        bus.freeze       = 1'b1;
        bus.Branch_taken = 1'b0;
        bus.BranchAddr   = 32'h0;
        bus.imem_we      = 1'b0;
        bus.imem_waddr   = 32'h0;
        bus.imem_wdata   = 32'h0;
        #2;
        checkResetState("rst0");

        // Memory is loaded while reset is held; reset must not disturb it.
        for (int i = 0; i < 64; i++) begin
            bus.imem_we    = 1'b1;
            bus.imem_waddr = 32'(i * 4);
            bus.imem_wdata = tbMem[i];
            step();
        end
        bus.imem_we = 1'b0;
        checkResetState("rstHold");

        // Basic streaming after reset release.
        bus.freeze = 1'b0;
        rst_n      = 1'b1;
        step();
        chk("firstValid", {31'b0, bus.valid}, 32'd1);
        pushExp(32'd0);
        pushExp(32'd4);
        pushExp(32'd8);
        drain(3);

        // Freeze saturation then release with no gaps or duplicates.
        bus.freeze = 1'b1;
        rst_n      = 1'b0;
        #2;
        checkResetState("rstB");
        rst_n    = 1'b1;
        expCount = 0;
        sb.delete();
        for (int i = 0; i < 10; i++) step();
        chk("frzValid", {31'b0, bus.valid}, 32'd1);
        chk("frzPC", bus.PC, 32'd4);
        chk("frzCount", bus.fetch_count, 32'd0);
        for (int a = 0; a <= 16; a += 4) pushExp(32'(a));
        drain(5);

        // Branch while frozen and full has priority over freeze and push.
        bus.freeze = 1'b1;
        step();
        step();
        bus.Branch_taken = 1'b1;
        bus.BranchAddr   = 32'h93;
        step();
        bus.Branch_taken = 1'b0;
        chk("brFullValid", {31'b0, bus.valid}, 32'd0);
        chk("brFullPC", bus.PC, 32'd0);
        chk("brFullCount", bus.fetch_count, expCount);
        step();
        chk("brTgtValid", {31'b0, bus.valid}, 32'd1);
        chk("brTgtPC", bus.PC, 32'h94);
        chk("brTgtInstr", bus.Instruction, tbMem[36]);
        sb.delete();
        pushExp(32'h90);
        pushExp(32'h94);
        drain(2);

        // Address wrap at the top of instruction memory.
        branchTo(32'd248);
        pushExp(32'd248);
        pushExp(32'd252);
        pushExp(32'd256);
        drain(3);

        // Write collision: the entry fetched during the write carries old data.
        bus.freeze = 1'b1;
        branchTo(32'd0);
        step();
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 32'd8;
        bus.imem_wdata = 32'h0;
        pushExp(32'd0);
        pushExp(32'd4);
        pushExp(32'd8);
        step();
        bus.imem_we = 1'b0;
        tbMem[2]    = 32'h0;
        drain(3);
        bus.freeze = 1'b1;
        branchTo(32'd8);
        chk("newDataPC", bus.PC, 32'd12);
        chk("newDataInstr", bus.Instruction, 32'h0);

        // Partial-cycle reset pulse with three entries buffered.
        branchTo(32'd0);
        step();
        step();
        chk("pre3PC", bus.PC, 32'd4);
        rst_n = 1'b0;
        #2;
        checkResetState("rstF");
        bus.freeze = 1'b0;
        #1;
        rst_n    = 1'b1;
        expCount = 0;
        step();
        chk("restartValid", {31'b0, bus.valid}, 32'd1);
        chk("restartPC", bus.PC, 32'd4);
        chk("restartInstr", bus.Instruction, 32'hE3A00014);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/if_stage_prefetch.md
IF_STAGE_PREFETCH -- requirements
Module: if_stage_prefetch

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64: instruction memory depth in 32-bit words, a power of two.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: prefetch buffer entries, a power of two, minimum 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: fetch address after reset.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 freeze  input  1  consumer stall; head entry not consumed this cycle.
REQ-008 Branch_taken  input  1  redirect request, sampled at the rising edge.
REQ-009 BranchAddr  input  32  redirect byte address.
REQ-010 imem_we  input  1  instruction memory write strobe.
REQ-011 imem_waddr  input  32  write byte address.
REQ-012 imem_wdata  input  32  write data word.
REQ-013 valid  output  1  head entry present.
REQ-014 PC  output  32  head entry fetch address + 4.
REQ-015 Instruction  output  32  head entry instruction word.
REQ-016 fetch_count  output  32  number of instructions consumed.

Function
REQ-017 Memory SHALL be IMEM_WORDS x 32; word index = address[log2(IMEM_WORDS)+1:2]; bits [1:0] ignored; higher bits ignored, so addresses wrap modulo 4*IMEM_WORDS.
REQ-018 Memory write SHALL occur at the rising edge when imem_we=1; a fetch of the same word in that cycle SHALL return the old data.
REQ-019 Memory contents SHALL NOT be changed by reset.
REQ-020 Internal fetch pointer fpc SHALL read the memory combinationally each cycle.
REQ-021 Push condition: buffer not full, or a pop occurs in the same cycle; Branch_taken=0.
REQ-022 On push, the buffer SHALL store {fpc+4, mem[fpc]} and fpc SHALL advance by 4 with 32-bit wrap.
REQ-023 Pop condition SHALL be valid=1 and freeze=0; fetch_count SHALL increment on each pop and wrap at 2^32.
REQ-024 valid SHALL be 1 exactly when occupancy is nonzero.
REQ-025 PC and Instruction SHALL present the head entry, and SHALL be 0 when the buffer is empty.
REQ-026 Simultaneous push and pop at full SHALL keep occupancy at FIFO_DEPTH; at empty, no pop occurs.
REQ-027 When Branch_taken=1 at an edge, the block SHALL:
- flush the buffer to occupancy 0;
- set fpc to {BranchAddr[31:2],2'b00};
- perform no push or pop that cycle; fetch_count SHALL be unchanged.
REQ-028 After a branch edge, valid SHALL be 0 for that cycle; the target entry SHALL be pushed at the next edge, giving a 2-edge redirect-to-valid latency.
REQ-029 Branch_taken SHALL take priority over freeze, pop and push.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH) bits plus a wrap bit; full/empty SHALL be derived without a separate counter race.

Reset
REQ-031 rst_n=0 SHALL immediately set:
- fpc=RESET_PC;
- buffer empty, valid=0, PC=0, Instruction=0;
- fetch_count=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries, with no partial output.
REQ-033 The first push SHALL occur at the first rising edge with rst_n=1; valid=1 SHALL follow that edge.

Verification
REQ-034 Preload mem[0]=32'hE3A00014 and mem[1]=32'hE3A01A01, release reset, freeze=0 -> edge1: valid=1, PC=4, Instruction=E3A00014; edge2: PC=8, Instruction=E3A01A01; fetch_count=1.
REQ-035 Hold freeze=1 for 10 cycles after reset -> occupancy saturates at FIFO_DEPTH=4 and fpc stops at 16. Release freeze -> PC sequence 4, 8, 12, 16, 20 with no gaps or duplicates.
REQ-036 Assert Branch_taken=1 with BranchAddr=32'h93 while freeze=1 and the buffer is full -> next cycle valid=0 and fetch_count unchanged; following cycle valid=1, PC=32'h94, Instruction=mem[36].
REQ-037 Sequential fetch to address 4*IMEM_WORDS-4=252 -> next entry has PC=256 with Instruction=mem[63]; the following entry shows Instruction=mem[0] (address wrap).
REQ-038 Write mem[2]=32'h0 with imem_we in the same cycle fpc=8 -> the pushed entry carries the old mem[2]; after a branch back to 8, the new value 0 is fetched.
REQ-039 Pulse rst_n low for a partial cycle with 3 entries buffered -> valid=0, PC=0, fetch_count=0 at once; restart yields PC=4 after the first edge.
